// File: rtl/multi_cycle_control_fsm.sv
// Control FSM for the multi-cycle RV32I core: sequences IF/ID/EX/MEM/WB with memory-ready
// handshaking, an ECALL halt and a retired-instruction counter.
module multi_cycle_control_fsm #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           opcode,
  input  logic                 bcond,
  input  logic [31:0]          x17_val,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 pc_write,
  output logic [1:0]           pc_source,
  output logic                 is_halted,
  output logic [CNT_WIDTH-1:0] retire_count
);

  localparam logic [6:0] OpLoad     = 7'b0000011;
  localparam logic [6:0] OpStore    = 7'b0100011;
  localparam logic [6:0] OpArith    = 7'b0110011;
  localparam logic [6:0] OpArithImm = 7'b0010011;
  localparam logic [6:0] OpBranch   = 7'b1100011;
  localparam logic [6:0] OpJal      = 7'b1101111;
  localparam logic [6:0] OpJalr     = 7'b1100111;
  localparam logic [6:0] OpEcall    = 7'b1110011;

  typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb, StHalt} state_e;

  state_e                state_q, state_d;
  logic                  halted_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  retire;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIf;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + CNT_WIDTH'(1);
      if (state_q == StId && state_d == StHalt) halted_q <= 1'b1;
    end
  end

  // Everything is held at zero while reset_n is low, so an aborted access never leaks out.
  assign is_halted    = halted_q & reset_n;
  assign retire_count = reset_n ? count_q : '0;

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_or_d    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    alu_op    = 2'd0;
    pc_write  = 1'b0;
    pc_source = 2'd0;
    if (reset_n) begin
      unique case (state_q)
        StIf: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            state_d  = StId;
          end
        end
        StId: begin
          alu_src_b = 2'd1;
          if (opcode == OpEcall && x17_val == HALT_CODE) state_d = StHalt;
          else                                           state_d = StEx;
        end
        StEx: begin
          case (opcode)
            OpArith: begin
              alu_src_a = 1'b1;
              alu_op    = 2'd2;
              state_d   = StWb;
            end
            OpArithImm: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'd1;
              alu_op    = 2'd2;
              state_d   = StWb;
            end
            OpLoad, OpStore: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'd1;
              state_d   = StMem;
            end
            OpBranch: begin
              alu_src_a = 1'b1;
              alu_op    = 2'd1;
              pc_write  = 1'b1;
              pc_source = bcond ? 2'd1 : 2'd0;
              retire    = 1'b1;
              state_d   = StIf;
            end
            OpJal: begin
              reg_write = 1'b1;
              wb_sel    = 2'd2;
              pc_write  = 1'b1;
              pc_source = 2'd1;
              retire    = 1'b1;
              state_d   = StIf;
            end
            OpJalr: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'd1;
              reg_write = 1'b1;
              wb_sel    = 2'd2;
              pc_write  = 1'b1;
              pc_source = 2'd2;
              retire    = 1'b1;
              state_d   = StIf;
            end
            default: begin
              // Non-halting ECALL and unknown opcodes retire as a NOP.
              pc_write = 1'b1;
              retire   = 1'b1;
              state_d  = StIf;
            end
          endcase
        end
        StMem: begin
          i_or_d = 1'b1;
          if (opcode == OpStore) mem_write = 1'b1;
          else                   mem_read  = 1'b1;
          if (mem_ready) begin
            if (opcode == OpStore) begin
              pc_write = 1'b1;
              retire   = 1'b1;
              state_d  = StIf;
            end else begin
              state_d = StWb;
            end
          end
        end
        StWb: begin
          reg_write = 1'b1;
          wb_sel    = (opcode == OpLoad) ? 2'd1 : 2'd0;
          pc_write  = 1'b1;
          retire    = 1'b1;
          state_d   = StIf;
        end
        StHalt: state_d = StHalt;
        default: state_d = StIf;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Bench for multi_cycle_control_fsm: per-instruction expected cycle schedules built from the
// instruction's class, driven from a directed table, hand-written corner cases and random programs.
module tb_multi_cycle_control_fsm;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] ARITH  = 7'b0110011;
  localparam logic [6:0] ARITHI = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] ECALL  = 7'b1110011;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic [1:0] pc_source;
  } ctrl_t;

  typedef struct {
    logic  mr;
    logic  bc;
    ctrl_t ctrl;
    bit    retire;
    bit    halt;
  } step_t;

  typedef struct {
    logic [6:0]  op;
    logic        bc;
    logic [31:0] x17;
    int          ifw;
    int          memw;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic        bcond = 1'b0;
  logic [31:0] x17_val = '0;
  logic        mem_ready = 1'b0;
  logic        mem_read, mem_write, i_or_d, ir_write, reg_write, alu_src_a, pc_write, is_halted;
  logic [1:0]  wb_sel, alu_src_b, alu_op, pc_source;
  logic [3:0]  retire_count;
  ctrl_t       dut_ctrl;

  int          checks = 0;
  int          failures = 0;
  logic [3:0]  model_cnt = '0;
  bit          model_halt = 1'b0;
  step_t       plan[$];
  vec_t        vecs[$];

  multi_cycle_control_fsm #(.CNT_WIDTH(4), .HALT_CODE(32'd10)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .bcond(bcond), .x17_val(x17_val),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_write(pc_write), .pc_source(pc_source),
    .is_halted(is_halted), .retire_count(retire_count)
  );

  assign dut_ctrl = {mem_read, mem_write, i_or_d, ir_write, reg_write, wb_sel, alu_src_a,
                     alu_src_b, alu_op, pc_write, pc_source};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout reached before end of test");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic step_t blank();
    step_t s;
    s.mr     = 1'($urandom);
    s.bc     = 1'($urandom);
    s.ctrl   = '0;
    s.retire = 1'b0;
    s.halt   = 1'b0;
    return s;
  endfunction

  // Expected cycle-by-cycle schedule of one instruction, from its class and the wait counts.
  task automatic plan_instr(input vec_t v);
    step_t s;
    for (int i = 0; i < v.ifw; i++) begin
      s = blank(); s.mr = 1'b0; s.ctrl.mem_read = 1'b1; plan.push_back(s);
    end
    s = blank(); s.mr = 1'b1; s.ctrl.mem_read = 1'b1; s.ctrl.ir_write = 1'b1; plan.push_back(s);
    s = blank(); s.ctrl.alu_src_b = 2'd1;
    if (v.op == ECALL && v.x17 == 32'd10) begin
      s.halt = 1'b1; plan.push_back(s);
      for (int i = 0; i < 3; i++) plan.push_back(blank());
      return;
    end
    plan.push_back(s);
    s = blank();
    case (v.op)
      ARITH, ARITHI: begin
        s.ctrl.alu_src_a = 1'b1;
        s.ctrl.alu_src_b = (v.op == ARITHI) ? 2'd1 : 2'd0;
        s.ctrl.alu_op    = 2'd2;
        plan.push_back(s);
        s = blank(); s.ctrl.reg_write = 1'b1; s.ctrl.pc_write = 1'b1; s.retire = 1'b1;
        plan.push_back(s);
      end
      LOAD, STORE: begin
        s.ctrl.alu_src_a = 1'b1; s.ctrl.alu_src_b = 2'd1; plan.push_back(s);
        for (int i = 0; i <= v.memw; i++) begin
          s = blank();
          s.mr = (i == v.memw);
          s.ctrl.i_or_d    = 1'b1;
          s.ctrl.mem_read  = (v.op == LOAD);
          s.ctrl.mem_write = (v.op == STORE);
          if (s.mr && v.op == STORE) begin s.ctrl.pc_write = 1'b1; s.retire = 1'b1; end
          plan.push_back(s);
        end
        if (v.op == LOAD) begin
          s = blank(); s.ctrl.reg_write = 1'b1; s.ctrl.wb_sel = 2'd1; s.ctrl.pc_write = 1'b1;
          s.retire = 1'b1; plan.push_back(s);
        end
      end
      BRANCH: begin
        s.bc = v.bc; s.ctrl.alu_src_a = 1'b1; s.ctrl.alu_op = 2'd1; s.ctrl.pc_write = 1'b1;
        s.ctrl.pc_source = v.bc ? 2'd1 : 2'd0; s.retire = 1'b1; plan.push_back(s);
      end
      JAL: begin
        s.ctrl.reg_write = 1'b1; s.ctrl.wb_sel = 2'd2; s.ctrl.pc_write = 1'b1;
        s.ctrl.pc_source = 2'd1; s.retire = 1'b1; plan.push_back(s);
      end
      JALR: begin
        s.ctrl.alu_src_a = 1'b1; s.ctrl.alu_src_b = 2'd1; s.ctrl.reg_write = 1'b1;
        s.ctrl.wb_sel = 2'd2; s.ctrl.pc_write = 1'b1; s.ctrl.pc_source = 2'd2;
        s.retire = 1'b1; plan.push_back(s);
      end
      default: begin
        s.ctrl.pc_write = 1'b1; s.retire = 1'b1; plan.push_back(s);
      end
    endcase
  endtask

  task automatic exec_steps(input vec_t v, input int n);
    step_t s;
    for (int i = 0; i < n && plan.size() > 0; i++) begin
      s = plan.pop_front();
      @(negedge clk);
      opcode = v.op; x17_val = v.x17; mem_ready = s.mr; bcond = s.bc;
      #1;
      check($sformatf("ctrl op=%b step=%0d", v.op, i), 32'(dut_ctrl), 32'(s.ctrl));
      check($sformatf("retire_count op=%b step=%0d", v.op, i), 32'(retire_count),
            32'(model_cnt));
      check($sformatf("is_halted op=%b step=%0d", v.op, i), 32'(is_halted), 32'(model_halt));
      @(posedge clk);
      if (s.retire) model_cnt = model_cnt + 4'd1;
      if (s.halt) model_halt = 1'b1;
    end
  endtask

  task automatic run_instr(input vec_t v);
    plan.delete();
    plan_instr(v);
    exec_steps(v, plan.size());
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset_n = 1'b0; mem_ready = 1'($urandom); bcond = 1'($urandom);
      #1;
      check($sformatf("reset ctrl cyc=%0d", i), 32'(dut_ctrl), 32'd0);
      check($sformatf("reset retire_count cyc=%0d", i), 32'(retire_count), 32'd0);
      check($sformatf("reset is_halted cyc=%0d", i), 32'(is_halted), 32'd0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_cnt  = '0;
    model_halt = 1'b0;
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic bc, input logic [31:0] x17,
                              input int ifw, input int memw);
    vec_t v;
    v.op = op; v.bc = bc; v.x17 = x17; v.ifw = ifw; v.memw = memw;
    return v;
  endfunction

  initial begin
    vec_t        v;
    logic [6:0]  ops[10];
    ops = '{ARITH, ARITHI, LOAD, STORE, BRANCH, JAL, JALR, ECALL, 7'h00, 7'h7f};

    vecs.push_back(mk(ARITH,  1'b0, 32'd0,  0, 0));
    vecs.push_back(mk(ARITHI, 1'b1, 32'd10, 0, 0));
    vecs.push_back(mk(LOAD,   1'b0, 32'd0,  0, 3));
    vecs.push_back(mk(LOAD,   1'b0, 32'd0,  2, 0));
    vecs.push_back(mk(STORE,  1'b0, 32'd0,  0, 0));
    vecs.push_back(mk(STORE,  1'b1, 32'd0,  1, 2));
    vecs.push_back(mk(BRANCH, 1'b1, 32'd0,  0, 0));
    vecs.push_back(mk(BRANCH, 1'b0, 32'd0,  0, 0));
    vecs.push_back(mk(JAL,    1'b0, 32'd0,  0, 0));
    vecs.push_back(mk(JALR,   1'b0, 32'd0,  3, 0));
    vecs.push_back(mk(ECALL,  1'b0, 32'd9,  0, 0));
    vecs.push_back(mk(7'h00,  1'b0, 32'd10, 1, 0));
    vecs.push_back(mk(ECALL,  1'b0, 32'd10, 0, 0));

    do_reset();
    foreach (vecs[i]) run_instr(vecs[i]);
    do_reset();

    // Reset while a STORE waits in MEM: write request must vanish and nothing retires.
    run_instr(mk(ARITH, 1'b0, 32'd0, 0, 0));
    v = mk(STORE, 1'b0, 32'd0, 0, 3);
    plan.delete();
    plan_instr(v);
    exec_steps(v, 4);
    plan.delete();
    @(negedge clk);
    reset_n = 1'b0; mem_ready = 1'b1;
    #1;
    check("store abort mem_write", 32'(mem_write), 32'd0);
    check("store abort ctrl", 32'(dut_ctrl), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_cnt = '0;
    run_instr(mk(ARITH, 1'b0, 32'd0, 0, 0));

    // Random programs; enough retires to wrap the narrow counter.
    for (int n = 0; n < 80; n++) begin
      v.op   = ops[$urandom_range(0, 9)];
      if (v.op == 7'h7f) v.op = 7'($urandom);
      v.bc   = 1'($urandom);
      v.x17  = ($urandom_range(0, 15) == 0) ? 32'd10 : 32'($urandom_range(0, 12));
      v.ifw  = $urandom_range(0, 3);
      v.memw = $urandom_range(0, 3);
      run_instr(v);
      if (model_halt) do_reset();
    end

    @(negedge clk);
    #1;
    check("final retire_count", 32'(retire_count), 32'(model_cnt));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
